// File: rtl/user_sw_debouncer.sv
// User switch debouncer: synchronizes raw switch pins, debounces them on a shared
// slow tick, and reports press/release edges plus long-press and auto-repeat pulses.
//
// state | meaning
// IDLE  | switch released, waiting for a debounced press
// SHORT | pressed, counting ticks toward the long-press threshold
// LONG  | long press already reported, counting ticks between repeat pulses
module user_sw_debouncer #(
    parameter int                   pChannels      = 4,
    parameter int                   pTickCycles    = 125000,
    parameter int                   pDebounceTicks = 4,
    parameter int                   pLongTicks     = 1000,
    parameter int                   pRepeatTicks   = 200,
    parameter logic [pChannels-1:0] pInvert        = '0
) (
    input  logic                 iSysClk,
    input  logic                 iSysRst,
    input  logic [pChannels-1:0] iUserSw,
    output logic [pChannels-1:0] oSwLevel,
    output logic [pChannels-1:0] oSwRise,
    output logic [pChannels-1:0] oSwFall,
    output logic [pChannels-1:0] oSwLong,
    output logic [pChannels-1:0] oSwRepeat
);

    localparam int TickW   = $clog2(pTickCycles);
    localparam int DbW     = (pDebounceTicks > 1) ? $clog2(pDebounceTicks) : 1;
    localparam int HoldMax = (pLongTicks > pRepeatTicks) ? pLongTicks : pRepeatTicks;
    localparam int HoldW   = $clog2(HoldMax + 1);
    localparam int RepLim  = (pRepeatTicks > 0) ? pRepeatTicks - 1 : 0;

    localparam logic [TickW-1:0] TickLast = TickW'(pTickCycles - 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(pDebounceTicks - 1);
    localparam logic [HoldW-1:0] LongLast = HoldW'(pLongTicks - 1);
    localparam logic [HoldW-1:0] RepLast  = HoldW'(RepLim);
    localparam logic [HoldW-1:0] HoldSat  = HoldW'(HoldMax);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } tHoldState;

    logic [pChannels-1:0] syncMeta;
    logic [pChannels-1:0] syncOut;
    logic [pChannels-1:0] swState;
    logic [pChannels-1:0] mismatch;
    logic [pChannels-1:0] toggle;
    logic [pChannels-1:0] riseEv;
    logic [pChannels-1:0] fallEv;
    logic [TickW-1:0]     tickCnt;
    logic                 tick;
    logic [DbW-1:0]       stabCnt   [pChannels];
    logic [HoldW-1:0]     holdCnt   [pChannels];
    tHoldState            holdState [pChannels];

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            syncMeta <= '0;
            syncOut  <= '0;
        end else begin
            syncMeta <= iUserSw;
            syncOut  <= syncMeta;
        end
    end

    // Active-low switches are flipped here so everything downstream sees 1 = pressed.
    assign swState = syncOut ^ pInvert;

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            tickCnt <= '0;
        end else if (tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    assign tick = (tickCnt == TickLast);

    always_comb begin
        mismatch = swState ^ oSwLevel;
        toggle   = '0;
        for (int i = 0; i < pChannels; i++) begin
            toggle[i] = mismatch[i] & tick & (stabCnt[i] == DbLast);
        end
    end

    assign riseEv = toggle & ~oSwLevel;
    assign fallEv = toggle & oSwLevel;

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            oSwLevel <= '0;
            oSwRise  <= '0;
            oSwFall  <= '0;
            for (int i = 0; i < pChannels; i++) begin
                stabCnt[i] <= '0;
            end
        end else begin
            oSwLevel <= oSwLevel ^ toggle;
            oSwRise  <= riseEv;
            oSwFall  <= fallEv;
            for (int i = 0; i < pChannels; i++) begin
                if (!mismatch[i] || toggle[i]) begin
                    stabCnt[i] <= '0;
                end else if (tick) begin
                    stabCnt[i] <= stabCnt[i] + 1'b1;
                end
            end
        end
    end

    // The FSM reacts to the same-edge toggle events so a release landing on the
    // long/repeat tick can suppress that pulse.
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            oSwLong   <= '0;
            oSwRepeat <= '0;
            for (int i = 0; i < pChannels; i++) begin
                holdState[i] <= IDLE;
                holdCnt[i]   <= '0;
            end
        end else begin
            oSwLong   <= '0;
            oSwRepeat <= '0;
            for (int i = 0; i < pChannels; i++) begin
                if (fallEv[i]) begin
                    holdState[i] <= IDLE;
                    holdCnt[i]   <= '0;
                end else begin
                    case (holdState[i])
                        IDLE: begin
                            if (riseEv[i]) begin
                                holdState[i] <= SHORT;
                                holdCnt[i]   <= '0;
                            end
                        end
                        SHORT: begin
                            if (tick) begin
                                if (holdCnt[i] == LongLast) begin
                                    holdState[i] <= LONG;
                                    holdCnt[i]   <= '0;
                                    oSwLong[i]   <= 1'b1;
                                end else if (holdCnt[i] != HoldSat) begin
                                    holdCnt[i] <= holdCnt[i] + 1'b1;
                                end
                            end
                        end
                        LONG: begin
                            if (tick && (pRepeatTicks > 0)) begin
                                if (holdCnt[i] == RepLast) begin
                                    holdCnt[i]   <= '0;
                                    oSwRepeat[i] <= 1'b1;
                                end else if (holdCnt[i] != HoldSat) begin
                                    holdCnt[i] <= holdCnt[i] + 1'b1;
                                end
                            end
                        end
                        default: begin
                            holdState[i] <= IDLE;
                            holdCnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_user_sw_debouncer.sv
// Bench for user_sw_debouncer: a time-based reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and pulse counts.
module tb_user_sw_debouncer;

    localparam int CH    = 4;
    localparam int TICK  = 10;
    localparam int DEB   = 3;
    localparam int LONGT = 5;
    localparam int REP   = 2;
    localparam logic [CH-1:0] INV = 4'b1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] sw;
    logic [CH-1:0] oSwLevel;
    logic [CH-1:0] oSwRise;
    logic [CH-1:0] oSwFall;
    logic [CH-1:0] oSwLong;
    logic [CH-1:0] oSwRepeat;

    user_sw_debouncer #(
        .pChannels      (CH),
        .pTickCycles    (TICK),
        .pDebounceTicks (DEB),
        .pLongTicks     (LONGT),
        .pRepeatTicks   (REP),
        .pInvert        (INV)
    ) dut (
        .iSysClk   (clk),
        .iSysRst   (rst),
        .iUserSw   (sw),
        .oSwLevel  (oSwLevel),
        .oSwRise   (oSwRise),
        .oSwFall   (oSwFall),
        .oSwLong   (oSwLong),
        .oSwRepeat (oSwRepeat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: values the registered outputs must hold after each edge.
    logic [CH-1:0] invV = INV;
    logic [CH-1:0] mSync1, mSync2, mLevel, mRise, mFall, mLong, mRep;
    int            mEdge;
    int            mRun     [CH];
    int            mHeld    [CH];
    bit            mPressed [CH];

    int riseCnt [CH];
    int fallCnt [CH];
    int longCnt [CH];
    int repCnt  [CH];
    int riseCyc [CH];
    int fallCyc [CH];
    int lastEvt [CH];

    task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chkInt(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chkRange(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at cycle %0d", nm, act, lo, hi, cyc);
        end
    endtask

    task automatic modelClear();
        mSync1 = '0; mSync2 = '0; mLevel = '0;
        mRise  = '0; mFall  = '0; mLong  = '0; mRep = '0;
        mEdge  = 0;
        for (int c = 0; c < CH; c++) begin
            mRun[c] = 0; mHeld[c] = 0; mPressed[c] = 1'b0;
        end
    endtask

    // Level flips on a tick once the synchronized input has disagreed with it on
    // every edge spanning DEB ticks; long/repeat derive from ticks counted since the press.
    task automatic modelStep();
        bit tick, s, mis, tog;
        tick = (mEdge % TICK) == TICK - 1;
        for (int c = 0; c < CH; c++) begin
            s   = mSync2[c] ^ invV[c];
            mis = (s != mLevel[c]);
            mRun[c] = mis ? mRun[c] + 1 : 0;
            tog = tick && mis && (mRun[c] >= (DEB - 1) * TICK + 1);
            mRise[c] = tog && !mLevel[c];
            mFall[c] = tog && mLevel[c];
            mLong[c] = 1'b0;
            mRep[c]  = 1'b0;
            if (tog) begin
                mRun[c]   = 0;
                mLevel[c] = ~mLevel[c];
            end
            if (mFall[c]) begin
                mPressed[c] = 1'b0;
            end else if (mRise[c]) begin
                mPressed[c] = 1'b1;
                mHeld[c]    = 0;
            end else if (mPressed[c] && tick) begin
                mHeld[c]++;
                if (mHeld[c] == LONGT) mLong[c] = 1'b1;
                else if (REP > 0 && mHeld[c] > LONGT && (mHeld[c] - LONGT) % REP == 0) mRep[c] = 1'b1;
            end
        end
        mSync2 = mSync1;
        mSync1 = sw;
        mEdge++;
    endtask

    // Inputs change only at negedge+2, so the value seen here is the one the last posedge sampled.
    initial begin
        modelClear();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) modelClear();
            else     modelStep();
            chk("level",  oSwLevel,  mLevel);
            chk("rise",   oSwRise,   mRise);
            chk("fall",   oSwFall,   mFall);
            chk("long",   oSwLong,   mLong);
            chk("repeat", oSwRepeat, mRep);
            for (int c = 0; c < CH; c++) begin
                if (oSwRise[c] === 1'b1) begin riseCnt[c]++; riseCyc[c] = cyc; end
                if (oSwFall[c] === 1'b1) begin fallCnt[c]++; fallCyc[c] = cyc; end
                if (oSwLong[c] === 1'b1) begin
                    longCnt[c]++;
                    chkInt("long_after_rise", cyc - riseCyc[c], 50);
                    lastEvt[c] = cyc;
                end
                if (oSwRepeat[c] === 1'b1) begin
                    repCnt[c]++;
                    chkInt("repeat_gap", cyc - lastEvt[c], 20);
                    lastEvt[c] = cyc;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic clearStats();
        for (int c = 0; c < CH; c++) begin
            riseCnt[c] = 0; fallCnt[c] = 0; longCnt[c] = 0; repCnt[c] = 0;
            riseCyc[c] = -1000; fallCyc[c] = -1000; lastEvt[c] = -1000;
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #1;
        chk("rst_level",  oSwLevel,  4'b0000);
        chk("rst_rise",   oSwRise,   4'b0000);
        chk("rst_fall",   oSwFall,   4'b0000);
        chk("rst_long",   oSwLong,   4'b0000);
        chk("rst_repeat", oSwRepeat, 4'b0000);
        cycles(3);
        rst = 1'b0;
    endtask

    int t0;

    initial begin
        sw = 4'b1000;
        clearStats();
        #1;
        applyReset();

        // Clean press on ch0, phase-aligned with reset release.
        clearStats();
        sw[0] = 1'b1;
        t0 = cyc;
        cycles(60);
        chkInt("a_rise_count", riseCnt[0], 1);
        chkInt("a_rise_latency", riseCyc[0] - t0, 30);
        chk("a_level", oSwLevel, 4'b0001);
        chkInt("a_other_rises", riseCnt[1] + riseCnt[2] + riseCnt[3], 0);
        chkInt("a_falls", fallCnt[0] + fallCnt[1] + fallCnt[2] + fallCnt[3], 0);
        sw[0] = 1'b0;
        cycles(60);
        chkInt("a_fall_count", fallCnt[0], 1);
        chk("a_level_released", oSwLevel, 4'b0000);

        // Bounce on ch0: toggles every 7 cycles, then a steady press.
        applyReset();
        clearStats();
        sw[0] = 1'b1;
        for (int k = 0; k < 27; k++) begin
            cycles(7);
            sw[0] = ~sw[0];
        end
        cycles(7);
        chkInt("b_bounce_rises", riseCnt[0], 0);
        chk("b_bounce_level", oSwLevel, 4'b0000);
        sw[0] = 1'b1;
        t0 = cyc;
        cycles(60);
        chkInt("b_rise_count", riseCnt[0], 1);
        chkRange("b_rise_latency", riseCyc[0] - t0, 22, 42);
        sw[0] = 1'b0;
        cycles(60);

        // Long press with repeat on ch2.
        applyReset();
        clearStats();
        sw[2] = 1'b1;
        cycles(1200);
        sw[2] = 1'b0;
        cycles(60);
        chkInt("c_rise_count", riseCnt[2], 1);
        chkInt("c_long_count", longCnt[2], 1);
        chkInt("c_repeat_count", repCnt[2], 57);
        chkInt("c_fall_count", fallCnt[2], 1);
        chkInt("c_fall_time", fallCyc[2] - riseCyc[2], 1200);

        // Release landing exactly on the long-press tick of ch1.
        applyReset();
        clearStats();
        sw[1] = 1'b1;
        cycles(30);
        chkInt("d_rise_count", riseCnt[1], 1);
        cycles(24);
        sw[1] = 1'b0;
        cycles(40);
        chkInt("d_fall_time", fallCyc[1] - riseCyc[1], 50);
        chkInt("d_no_long", longCnt[1], 0);
        chkInt("d_fall_count", fallCnt[1], 1);
        sw[1] = 1'b1;
        cycles(100);
        chkInt("d_long_after_idle", longCnt[1], 1);
        sw[1] = 1'b0;
        cycles(60);

        // Reset while ch1 is in a long press; switch stays pressed.
        applyReset();
        clearStats();
        sw[1] = 1'b1;
        for (int k = 0; k < 200 && longCnt[1] == 0; k++) cycles(1);
        chkInt("e_long_reached", longCnt[1], 1);
        cycles(5);
        applyReset();
        clearStats();
        t0 = cyc;
        cycles(60);
        chkInt("e_rise_count", riseCnt[1], 1);
        chkInt("e_rise_latency", riseCyc[1] - t0, 30);
        chkInt("e_no_fall", fallCnt[1], 0);
        sw[1] = 1'b0;
        cycles(60);

        // Active-low ch3: idle high stays released, pulling low presses.
        applyReset();
        clearStats();
        cycles(50);
        chk("f_idle_level", oSwLevel, 4'b0000);
        chkInt("f_idle_rises", riseCnt[3], 0);
        sw[3] = 1'b0;
        t0 = cyc;
        cycles(60);
        chkInt("f_rise_count", riseCnt[3], 1);
        chkInt("f_rise_latency", riseCyc[3] - t0, 30);
        chk("f_level", oSwLevel, 4'b1000);
        sw[3] = 1'b1;
        cycles(60);
        chkInt("f_fall_count", fallCnt[3], 1);

        // Simultaneous presses on ch0 and ch1 report in their own bits.
        clearStats();
        sw[0] = 1'b1;
        sw[1] = 1'b1;
        cycles(60);
        chkInt("g_rise0", riseCnt[0], 1);
        chkInt("g_rise1", riseCnt[1], 1);
        chkInt("g_same_cycle", riseCyc[0] - riseCyc[1], 0);
        chk("g_level", oSwLevel, 4'b0011);
        sw[0] = 1'b0;
        sw[1] = 1'b0;
        cycles(60);
        chk("g_level_released", oSwLevel, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached expected scenario completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/user_sw_debouncer.md
USER_SW_DEBOUNCER -- requirements
Module: user_sw_debouncer

Interface
REQ-001 SHALL have parameter pChannels, default 4: number of switch channels, legal range 1..32.
REQ-002 SHALL have parameter pTickCycles, default 125000: iSysClk cycles per debounce tick (1 ms at 125 MHz), minimum 2.
REQ-003 SHALL have parameter pDebounceTicks, default 4: consecutive mismatching ticks required to change the level, minimum 1.
REQ-004 SHALL have parameter pLongTicks, default 1000: ticks held before a long press is reported, minimum 1.
REQ-005 SHALL have parameter pRepeatTicks, default 200: auto-repeat period in ticks while long-pressed; 0 disables repeat.
REQ-006 SHALL have parameter pInvert, default all 0: per-channel bit, pChannels wide; 1 means the switch is active-low.
REQ-007 SHALL have port iSysClk, input, 1 bit: the single system clock; all logic runs on it.
REQ-008 SHALL have port iSysRst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port iUserSw, input, pChannels bits: raw asynchronous switch inputs.
REQ-010 SHALL have port oSwLevel, output, pChannels bits: debounced level; 1 means pressed.
REQ-011 SHALL have port oSwRise, output, pChannels bits: one-cycle pulse on a press.
REQ-012 SHALL have port oSwFall, output, pChannels bits: one-cycle pulse on a release.
REQ-013 SHALL have port oSwLong, output, pChannels bits: one-cycle pulse when a long press is reached.
REQ-014 SHALL have port oSwRepeat, output, pChannels bits: one-cycle auto-repeat pulse.

Function
REQ-015 SHALL pass each iUserSw bit through a 2-flop synchronizer, then XOR it with its pInvert bit to form the internal signal s.
REQ-016 SHALL use one shared free-running tick counter that counts 0..pTickCycles-1 and wraps; tick is high for one cycle when the count equals pTickCycles-1.
REQ-017 SHALL clear a channel's stability counter in any cycle where s equals oSwLevel, regardless of tick.
REQ-018 SHALL, on a tick where s differs from oSwLevel, increment the stability counter; when the counter equals pDebounceTicks-1, it SHALL toggle oSwLevel and clear the counter instead.
REQ-019 SHALL assert oSwRise or oSwFall in the same cycle that oSwLevel goes 1 or 0 respectively; these pulses SHALL be registered outputs.
REQ-020 SHALL give each channel an FSM with states IDLE, SHORT and LONG, plus a hold counter that saturates at max(pLongTicks, pRepeatTicks).
- IDLE -> SHORT on rise; the hold counter is cleared.
- SHORT: the hold counter increments on each tick. On the tick where it reaches pLongTicks, the FSM SHALL go to LONG, pulse oSwLong, and clear the counter.
- LONG with pRepeatTicks>0: the counter increments on each tick. On reaching pRepeatTicks, the block SHALL pulse oSwRepeat and clear the counter.
- Any state -> IDLE on fall; the counter is cleared.
REQ-021 SHALL give fall priority when fall coincides with the long-threshold or repeat tick: no oSwLong or oSwRepeat pulse, and the FSM goes to IDLE.
REQ-022 SHALL produce at most one oSwLong pulse per press.
REQ-023 SHALL have a press latency of 2 to 3 cycles of synchronizer delay plus pDebounceTicks ticks; the first tick may be partial.
REQ-024 SHALL keep channels fully independent; simultaneous events on different channels SHALL each be reported in their own bit.

Reset
REQ-025 SHALL, while iSysRst is high, asynchronously clear all outputs, the synchronizer flops, the tick counter and every per-channel counter, and force every FSM to IDLE.
REQ-026 SHALL, after reset mid-press, produce no fall pulse; a switch still pressed SHALL produce a new rise after the normal debounce latency.
REQ-027 SHALL keep oSwLevel at 0 after reset for an idle active-low channel (pInvert=1, pin high), with no rise pulse.

Verification (pChannels=4, pTickCycles=10, pDebounceTicks=3, pLongTicks=5, pRepeatTicks=2)
REQ-028 SHALL cover a clean press: ch0 driven to 1 and held -> oSwLevel[0]=1 within 2+30+10 cycles, exactly one oSwRise[0] pulse, and no other bits change.
REQ-029 SHALL cover bounce: ch0 toggled every 7 cycles for 200 cycles, then held at 1 -> no level change during bounce, then one rise within 42 cycles of the last edge.
REQ-030 SHALL cover a long press with repeat: ch2 held for 120 ticks -> oSwLong[2] exactly 5 ticks (50 cycles) after rise, then oSwRepeat[2] every 20 cycles, and one oSwFall[2] after release.
REQ-031 SHALL cover release at the threshold: fall is timed to coincide with the 5th hold tick -> oSwFall pulse only, no oSwLong, FSM returns to IDLE.
REQ-032 SHALL cover reset mid-press: iSysRst asserted during LONG on ch1 -> all outputs 0 immediately; after release with the switch still pressed, one oSwRise[1] appears after 3 ticks, with no fall.
REQ-033 SHALL cover an active-low channel: pInvert[3]=1 with pin held high from reset -> oSwLevel[3]=0 throughout; driving the pin low -> rise after 3 ticks.
